mul: RTL
========

# mul

Sequential fixed-point multiplier for the FPU datapath: the forward counterpart to the fixed-point divider, sharing its start/busy/valid/ovf handshake so the FPU control logic drives both blocks the same way. It computes q = (x·y) >> FBITS on unsigned WIDTH-bit fixed-point operands using one shift-add step per cycle. It flags results whose integer part does not fit in WIDTH−FBITS bits.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- FBITS, 7, fractional bits of x, y and q (0 ≤ FBITS < WIDTH; 0 = integer multiply)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; samples x, y on the same edge
- busy  out  1  multiplication in progress
- valid  out  1  q holds a valid, non-overflowed result
- ovf  out  1  last operation overflowed
- x  in  WIDTH  multiplicand, unsigned fixed point
- y  in  WIDTH  multiplier, unsigned fixed point
- q  out  WIDTH  product

## Operation
- Internal state: latched multiplicand x1 (WIDTH), latched multiplier y1 (WIDTH), product accumulator p (2·WIDTH bits), iteration counter i (enough bits to hold WIDTH−1).
- States: IDLE (busy=0) and RUN (busy=1). There is no separate done state; the outputs carry the result.
- IDLE → RUN on start. Latch x1←x, y1←y, p←0, i←0, busy←1, valid←0, ovf←0.
- RUN, each cycle: if y1[i]=1 then p←p + (x1 << i), else p is unchanged. i←i+1. The add is full 2·WIDTH width with no truncation.
- RUN, when i=WIDTH−1 (last step), form the final product P = p_next:
  - P[2·WIDTH−1 : WIDTH+FBITS] = 0: q←P[WIDTH+FBITS−1 : FBITS], valid←1, ovf←0.
  - Otherwise: q←0, ovf←1, valid stays 0.
  - In both cases busy←0 and the block returns to IDLE.
- Rounding: truncation toward zero. Discarded fraction bits P[FBITS−1:0] are dropped.
- When FBITS=0 the slice is P[WIDTH−1:0] and the overflow field is P[2·WIDTH−1:WIDTH]. The implementation must not create a zero- or negative-width vector.
- Either operand zero takes the normal path and produces q=0, valid=1. There is no early exit.
- start while busy aborts the current operation and restarts with the new x, y. The same latch rules apply and the aborted result is never presented.
- start is ignored on a reset cycle, because reset has priority.
- q and ovf hold their values until the next completion or reset.

## Timing
- Reset values: busy=0, valid=1, ovf=0, q=0; internal state is don't-care.
- The start edge is E0. Steps run at edges E1..EWIDTH, and busy is high for exactly WIDTH cycles.
- At edge EWIDTH: busy falls, q/ovf update, and valid rises (no overflow). The result is visible in the cycle after EWIDTH.
- valid falls in the cycle after the start edge.
- Back-to-back: start may be asserted in the first cycle busy=0, giving a throughput of one result per WIDTH+1 cycles.
- Reset asserted mid-RUN: next cycle busy=0, valid=1, ovf=0, q=0, and no result is produced.
- x and y are don't-care except on the start edge.

## Test plan
- Reset, WIDTH=8, FBITS=7: after reset busy=0, valid=1, ovf=0, q=0x00.
- Q1.7 products, one per start:
  - 0x40·0x40 → q=0x20 (0.25)
  - 0x80·0x80 → q=0x80
  - 0xFF·0x01 → q=0x01
  - 0x01·0x01 → q=0x00
  - For each: busy high exactly 8 cycles, valid=1, ovf=0.
- Overflow, Q1.7: 0xC0·0xC0 (P=0x9000) → ovf=1, q=0x00, valid=0, busy low after 8 cycles. A following 0x40·0x40 then gives valid=1, ovf=0, q=0x20.
- Integer mode, WIDTH=8, FBITS=0:
  - 15·17 → q=0xFF, ovf=0
  - 16·16 → ovf=1, q=0
  - 0·0xFF → q=0, valid=1
- Abort and reset:
  - start 0x80·0x80, then at cycle 3 start 0x40·0x40 → only the result q=0x20 appears, valid 8 cycles after the second start.
  - start, then reset at cycle 4 → busy=0, valid=1, q=0 next cycle.
- Random: 1000 random x, y at WIDTH=8/FBITS=7 and WIDTH=16/FBITS=8, back-to-back starts, compared against the reference model.
  - Model: P=x·y; ovf=(P>>(WIDTH+FBITS))≠0; q=ovf?0:(P>>FBITS) mod 2^WIDTH.

Source files
------------

// File: rtl/mul.sv
// Sequential unsigned fixed-point multiplier: q = (x*y) >> FBITS, one shift-add step per cycle.
// Shares the start/busy/valid/ovf handshake with the fixed-point divider.
//
// state | meaning
// IDLE  | waiting for start; q/valid/ovf hold the last result
// RUN   | one shift-add step per cycle, WIDTH steps in total
module mul #(
  parameter int WIDTH = 8,
  parameter int FBITS = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   x1;
  logic [WIDTH-1:0]   y1;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [IW-1:0]      i;
  logic [WIDTH-1:0]   prod;
  logic               ovf_hit;

  // Shifting the full product avoids zero-width slices when FBITS = 0.
  always_comb begin
    p_next = p;
    if (y1[i]) p_next = p + ({{WIDTH{1'b0}}, x1} << i);
    prod    = WIDTH'(p_next >> FBITS);
    ovf_hit = (p_next >> (WIDTH + FBITS)) != '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b1;
      ovf   <= 1'b0;
      q     <= '0;
    end else if (start) begin
      // Also the abort path: a start during RUN simply restarts.
      x1    <= x;
      y1    <= y;
      p     <= '0;
      i     <= '0;
      busy  <= 1'b1;
      valid <= 1'b0;
      ovf   <= 1'b0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          p <= p_next;
          i <= i + IW'(1);
          if (i == LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (ovf_hit) begin
              q   <= '0;
              ovf <= 1'b1;
            end else begin
              q     <= prod;
              valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
